// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - command codes, frame geometry and FSM encoding for uart_cmd_decoder
package uart_cmd_pkg;

  localparam int DEF_FRAME_BYTES = 18;
  localparam int DEF_DBITS       = 8;

  localparam logic [7:0] CMD_TEST  = 8'h41;  // 'A'
  localparam logic [7:0] CMD_READ  = 8'h42;  // 'B'
  localparam logic [7:0] CMD_KEY   = 8'h43;  // 'C'
  localparam logic [7:0] CMD_TEXT  = 8'h44;  // 'D'
  localparam logic [7:0] CMD_ENC   = 8'h45;  // 'E'
  localparam logic [7:0] RSP_NORES = 8'h21;  // '!'

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DISPATCH = 2'd1;
  localparam logic [1:0] ST_WAIT_AES = 2'd2;
  localparam logic [1:0] ST_TX_WAIT  = 2'd3;

  // Byte 0 sits at the LSB, so the text reads back-to-front: wire order is "1234...78".
  localparam logic [143:0] TEST_RSP = "876543210987654321";

endpackage

// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - frame validation, command dispatch, AES handshake and TX response
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int FRAME_BYTES = DEF_FRAME_BYTES,
  parameter int DBITS       = DEF_DBITS,
  parameter int AES_TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [FRAME_BYTES*DBITS-1:0] rx_frame,
  input  logic                         rx_valid,
  input  logic                         tx_busy,
  output logic [FRAME_BYTES*DBITS-1:0] tx_frame,
  output logic                         tx_send,
  output logic [(FRAME_BYTES-2)*DBITS-1:0] aes_key,
  output logic [(FRAME_BYTES-2)*DBITS-1:0] aes_text_in,
  output logic                         aes_ld,
  input  logic                         aes_done,
  input  logic [(FRAME_BYTES-2)*DBITS-1:0] aes_text_out,
  output logic [7:0]                   err_count,
  output logic [DBITS-1:0]             last_cmd
);

  localparam int FW = FRAME_BYTES * DBITS;
  localparam int PW = (FRAME_BYTES - 2) * DBITS;
  localparam int TW = $clog2(AES_TIMEOUT + 1);

  logic [1:0]       state_q, state_d;
  logic [FW-1:0]    rx_buf_q, rx_buf_d;
  logic [FW-1:0]    tx_frame_q, tx_frame_d;
  logic             tx_send_q, tx_send_d;
  logic [PW-1:0]    aes_key_q, aes_key_d;
  logic [PW-1:0]    aes_text_q, aes_text_d;
  logic             aes_ld_q, aes_ld_d;
  logic [PW-1:0]    result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic [7:0]       err_count_q, err_count_d;
  logic [DBITS-1:0] last_cmd_q, last_cmd_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;

  logic [DBITS-1:0] cmd, cmd_tail;
  logic [PW-1:0]    payload;
  logic [1:0]       err_inc;
  logic [8:0]       err_sum;

  assign cmd      = rx_buf_q[DBITS-1:0];
  assign cmd_tail = rx_buf_q[FW-1 -: DBITS];
  assign payload  = rx_buf_q[FW-DBITS-1:DBITS];

  always_comb begin
    state_d        = state_q;
    rx_buf_d       = rx_buf_q;
    tx_frame_d     = tx_frame_q;
    tx_send_d      = 1'b0;
    aes_key_d      = aes_key_q;
    aes_text_d     = aes_text_q;
    aes_ld_d       = 1'b0;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    last_cmd_d     = last_cmd_q;
    tmo_cnt_d      = tmo_cnt_q;
    err_inc        = 2'd0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          rx_buf_d = rx_frame;
          state_d  = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        state_d = ST_IDLE;
        if (cmd != cmd_tail) begin
          err_inc = err_inc + 2'd1;
        end else begin
          case (cmd)
            CMD_TEST: begin
              last_cmd_d = cmd;
              tx_frame_d = TEST_RSP;
              state_d    = ST_TX_WAIT;
            end
            CMD_READ: begin
              last_cmd_d = cmd;
              tx_frame_d = result_valid_q ? {CMD_READ, result_q, CMD_READ}
                                          : {RSP_NORES, {PW{1'b0}}, RSP_NORES};
              state_d    = ST_TX_WAIT;
            end
            CMD_KEY: begin
              last_cmd_d     = cmd;
              aes_key_d      = payload;
              result_valid_d = 1'b0;
            end
            CMD_TEXT: begin
              last_cmd_d     = cmd;
              aes_text_d     = payload;
              result_valid_d = 1'b0;
            end
            CMD_ENC: begin
              last_cmd_d     = cmd;
              aes_ld_d       = 1'b1;
              result_valid_d = 1'b0;
              tmo_cnt_d      = '0;
              state_d        = ST_WAIT_AES;
            end
            default: err_inc = err_inc + 2'd1;
          endcase
        end
      end
      // A done arriving on the last allowed cycle still counts as a result.
      ST_WAIT_AES: begin
        if (aes_done) begin
          result_d       = aes_text_out;
          result_valid_d = 1'b1;
          state_d        = ST_IDLE;
        end else if (tmo_cnt_q == TW'(AES_TIMEOUT - 1)) begin
          err_inc = err_inc + 2'd1;
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_TX_WAIT: begin
        if (!tx_busy) begin
          tx_send_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rx_valid && (state_q != ST_IDLE)) err_inc = err_inc + 2'd1;

    err_sum     = {1'b0, err_count_q} + {7'd0, err_inc};
    err_count_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      rx_buf_q       <= '0;
      tx_frame_q     <= '0;
      tx_send_q      <= 1'b0;
      aes_key_q      <= '0;
      aes_text_q     <= '0;
      aes_ld_q       <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      err_count_q    <= '0;
      last_cmd_q     <= '0;
      tmo_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      rx_buf_q       <= rx_buf_d;
      tx_frame_q     <= tx_frame_d;
      tx_send_q      <= tx_send_d;
      aes_key_q      <= aes_key_d;
      aes_text_q     <= aes_text_d;
      aes_ld_q       <= aes_ld_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      err_count_q    <= err_count_d;
      last_cmd_q     <= last_cmd_d;
      tmo_cnt_q      <= tmo_cnt_d;
    end
  end

  assign tx_frame    = tx_frame_q;
  assign tx_send     = tx_send_q;
  assign aes_key     = aes_key_q;
  assign aes_text_in = aes_text_q;
  assign aes_ld      = aes_ld_q;
  assign err_count   = err_count_q;
  assign last_cmd    = last_cmd_q;

endmodule
